// File: rtl/cpu_output_scanner_if.sv
//------------------------------------------------------------------------------
// cpu_output_scanner_if : display-side and register-file-side signal bundle.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cpu_output_scanner_if #(
   parameter int DATA_W = 32,
   parameter int SEL_W  = 4
);
   logic              i_mode;
   logic [SEL_W-1:0]  i_output_sel;
   logic              i_snap_req;
   logic              i_snap_clr;
   logic [SEL_W-1:0]  o_reg_rd_addr;
   logic [DATA_W-1:0] i_reg_rd_data;
   logic [DATA_W-1:0] o_cpu_output;
   logic [SEL_W-1:0]  o_view_idx;
   logic              o_snap_valid;
   logic              o_snap_busy;
   logic              o_snap_done;
   logic [DATA_W-1:0] o_snap_sum;

   modport slave (
      input  i_mode, i_output_sel, i_snap_req, i_snap_clr, i_reg_rd_data,
      output o_reg_rd_addr, o_cpu_output, o_view_idx,
             o_snap_valid, o_snap_busy, o_snap_done, o_snap_sum
   );

   modport master (
      output i_mode, i_output_sel, i_snap_req, i_snap_clr, i_reg_rd_data,
      input  o_reg_rd_addr, o_cpu_output, o_view_idx,
             o_snap_valid, o_snap_busy, o_snap_done, o_snap_sum
   );
endinterface

`default_nettype wire

// File: rtl/cpu_output_scanner.sv
//------------------------------------------------------------------------------
// cpu_output_scanner : manual/auto-scan register viewer with atomic snapshot.
// Optional checksum of each snapshot enabled by macro SCAN_CHECKSUM_EN.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_output_scanner #(
   parameter int DATA_W       = 32,
   parameter int NUM_REGS     = 16,
   parameter int SEL_W        = 4,
   parameter int DWELL_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cpu_output_scanner_if.slave  bus
);

   localparam int                c_DWELL_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [SEL_W:0]    c_NUM_REGS  = (SEL_W+1)'(NUM_REGS);
   localparam logic [SEL_W-1:0]  c_LAST_IDX  = SEL_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      ST_LIVE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_VIEW    = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_mode_d;
   logic [SEL_W-1:0]    r_auto_idx;
   logic [c_DWELL_W-1:0] r_dwell;
   logic [SEL_W-1:0]    r_cap_addr;
   logic [DATA_W-1:0]   r_buf [NUM_REGS];
   logic [DATA_W-1:0]   r_cpu_output;
   logic [SEL_W-1:0]    r_view_idx;
   logic                r_snap_valid;
   logic                r_snap_done;
   logic [DATA_W-1:0]   w_snap_sum;

   logic                w_sel_in_range;
   logic [SEL_W-1:0]    w_seed;
   logic                w_switch;
   logic [SEL_W-1:0]    w_auto_cur;
   logic [c_DWELL_W-1:0] w_dwell_cur;
   logic [SEL_W-1:0]    w_auto_next;
   logic [SEL_W-1:0]    w_idx;
   logic                w_idx_in_range;
   logic                w_cap_last;
   logic                w_use_buf;
   logic [DATA_W-1:0]   w_disp_data;
   logic [SEL_W-1:0]    w_rd_addr;
   logic                w_busy;

   // A manual->auto switch behaves as if the seeded index had just started its dwell
   assign w_sel_in_range = ({1'b0, bus.i_output_sel} < c_NUM_REGS);
   assign w_seed         = w_sel_in_range ? bus.i_output_sel : '0;
   assign w_switch       = bus.i_mode & ~r_mode_d;
   assign w_auto_cur     = w_switch ? w_seed : r_auto_idx;
   assign w_dwell_cur    = w_switch ? '0 : r_dwell;
   assign w_auto_next    = (w_auto_cur == c_LAST_IDX) ? '0 : w_auto_cur + 1'b1;
   assign w_idx          = bus.i_mode ? w_auto_cur : bus.i_output_sel;
   assign w_idx_in_range = ({1'b0, w_idx} < c_NUM_REGS);
   assign w_cap_last     = (r_cap_addr == c_LAST_IDX);

   always_comb begin
      w_state_nxt = r_state;
      w_rd_addr   = w_idx;
      w_busy      = 1'b0;
      case (r_state)
         ST_LIVE: begin
            if (bus.i_snap_req) w_state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_rd_addr = r_cap_addr;
            w_busy    = 1'b1;
            if (w_cap_last) w_state_nxt = ST_VIEW;
         end
         ST_VIEW: begin
            if (bus.i_snap_req)      w_state_nxt = ST_CAPTURE;
            else if (bus.i_snap_clr) w_state_nxt = ST_LIVE;
         end
         default: w_state_nxt = ST_LIVE;
      endcase
   end

   // Leaving VIEW via snap_clr shows live data on the same edge snap_valid drops
   assign w_use_buf   = (r_state == ST_VIEW) && (w_state_nxt != ST_LIVE);
   assign w_disp_data = !w_idx_in_range ? '0 :
                        w_use_buf       ? r_buf[w_idx] : bus.i_reg_rd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_LIVE;
         r_mode_d     <= 1'b0;
         r_auto_idx   <= '0;
         r_dwell      <= '0;
         r_cap_addr   <= '0;
         r_cpu_output <= '0;
         r_view_idx   <= '0;
         r_snap_valid <= 1'b0;
         r_snap_done  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_snap_done <= 1'b0;
         if (r_state == ST_CAPTURE) begin
            r_cap_addr <= w_cap_last ? '0 : r_cap_addr + 1'b1;
            if (w_cap_last) begin
               r_snap_done  <= 1'b1;
               r_snap_valid <= 1'b1;
            end
         end else begin
            r_cpu_output <= w_disp_data;
            r_view_idx   <= w_idx;
            r_mode_d     <= bus.i_mode;
            if (bus.i_mode) begin
               if (w_dwell_cur == c_DWELL_LAST) begin
                  r_auto_idx <= w_auto_next;
                  r_dwell    <= '0;
               end else begin
                  r_auto_idx <= w_auto_cur;
                  r_dwell    <= w_dwell_cur + 1'b1;
               end
            end
            if ((r_state == ST_VIEW) && (w_state_nxt == ST_LIVE))
               r_snap_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == ST_CAPTURE)
         r_buf[r_cap_addr] <= bus.i_reg_rd_data;
   end

`ifdef SCAN_CHECKSUM_EN
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_snap_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_snap_sum <= '0;
      end else if (r_state == ST_CAPTURE) begin
         if (w_cap_last) begin
            r_acc      <= '0;
            r_snap_sum <= r_acc + bus.i_reg_rd_data;
         end else begin
            r_acc      <= r_acc + bus.i_reg_rd_data;
         end
      end
   end

   assign w_snap_sum = r_snap_sum;
`else
   assign w_snap_sum = '0;
`endif

   assign bus.o_reg_rd_addr = w_rd_addr;
   assign bus.o_cpu_output  = r_cpu_output;
   assign bus.o_view_idx    = r_view_idx;
   assign bus.o_snap_valid  = r_snap_valid;
   assign bus.o_snap_busy   = w_busy;
   assign bus.o_snap_done   = r_snap_done;
   assign bus.o_snap_sum    = w_snap_sum;

endmodule

`default_nettype wire

// File: tb/tb_cpu_output_scanner.sv
//------------------------------------------------------------------------------
// tb_cpu_output_scanner : directed vectors and snapshot sequences for two configs.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_output_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        t_mode, t_req, t_clr;
   logic [3:0]  t_sel;
   logic [31:0] regfile [16];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cpu_output_scanner_if #(.DATA_W(32), .SEL_W(4)) bus_a ();
   cpu_output_scanner_if #(.DATA_W(32), .SEL_W(4)) bus_b ();

   assign bus_a.i_mode        = t_mode;
   assign bus_a.i_output_sel  = t_sel;
   assign bus_a.i_snap_req    = t_req;
   assign bus_a.i_snap_clr    = t_clr;
   assign bus_a.i_reg_rd_data = regfile[bus_a.o_reg_rd_addr];

   assign bus_b.i_mode        = t_mode;
   assign bus_b.i_output_sel  = t_sel;
   assign bus_b.i_snap_req    = 1'b0;
   assign bus_b.i_snap_clr    = 1'b0;
   assign bus_b.i_reg_rd_data = regfile[bus_b.o_reg_rd_addr];

   cpu_output_scanner #(.DATA_W(32), .NUM_REGS(16), .SEL_W(4), .DWELL_CYCLES(2)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   cpu_output_scanner #(.DATA_W(32), .NUM_REGS(10), .SEL_W(4), .DWELL_CYCLES(3)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   typedef struct {
      logic [3:0]  sel;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   vec_t       vecs [6];
   logic [3:0] auto_exp [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_regs(input int mul, input int add);
      for (int i = 0; i < 16; i++) regfile[i] = 32'(i * mul + add);
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!bus_a.o_snap_done && cycles < 40);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int c;
      logic [31:0] exp_sum1, exp_sum2;
      int done_seen;
`ifdef SCAN_CHECKSUM_EN
      exp_sum1 = 32'd120;
      exp_sum2 = 32'd1720;
`else
      exp_sum1 = 32'd0;
      exp_sum2 = 32'd0;
`endif
      vecs[0] = '{4'd0,  32'd0,  32'd0};
      vecs[1] = '{4'd4,  32'd12, 32'd12};
      vecs[2] = '{4'd9,  32'd27, 32'd27};
      vecs[3] = '{4'd10, 32'd30, 32'd0};
      vecs[4] = '{4'd12, 32'd36, 32'd0};
      vecs[5] = '{4'd15, 32'd45, 32'd0};
      auto_exp[0] = 4'd14; auto_exp[1] = 4'd14; auto_exp[2] = 4'd15;
      auto_exp[3] = 4'd15; auto_exp[4] = 4'd0;  auto_exp[5] = 4'd0;

      // Reset with busy register file
      rst_n = 1'b0;
      t_mode = 1'b0; t_sel = 4'd0; t_req = 1'b0; t_clr = 1'b0;
      set_regs(5, 1);
      repeat (5) step();
      check("rst cpu_output", bus_a.o_cpu_output, 32'd0);
      check("rst view_idx",   32'(bus_a.o_view_idx), 32'd0);
      check("rst rd_addr",    32'(bus_a.o_reg_rd_addr), 32'd0);
      check("rst snap_valid", 32'(bus_a.o_snap_valid), 32'd0);
      check("rst snap_busy",  32'(bus_a.o_snap_busy), 32'd0);
      check("rst snap_done",  32'(bus_a.o_snap_done), 32'd0);
      check("rst snap_sum",   bus_a.o_snap_sum, 32'd0);

      rst_n = 1'b1;
      regfile[4] = 32'h0000_0007;
      t_sel = 4'd4;
      step();
      check("live sel4 out", bus_a.o_cpu_output, 32'd7);
      check("live sel4 idx", 32'(bus_a.o_view_idx), 32'd4);

      // Manual vectors on both configurations
      set_regs(3, 0);
      for (int i = 0; i < 6; i++) begin
         t_sel = vecs[i].sel;
         step();
         check("vec a out", bus_a.o_cpu_output, vecs[i].exp_a);
         check("vec a idx", 32'(bus_a.o_view_idx), 32'(vecs[i].sel));
         check("vec b out", bus_b.o_cpu_output, vecs[i].exp_b);
         check("vec b idx", 32'(bus_b.o_view_idx), 32'(vecs[i].sel));
      end

      // Auto-scan wrap; B seeds from out-of-range select to 0, dwell 3
      t_sel = 4'd14;
      t_mode = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check("auto a idx", 32'(bus_a.o_view_idx), 32'(auto_exp[k]));
         check("auto a out", bus_a.o_cpu_output, 32'(auto_exp[k]) * 3);
         check("auto b idx", 32'(bus_b.o_view_idx), (k < 3) ? 32'd0 : 32'd1);
         check("auto b out", bus_b.o_cpu_output, (k < 3) ? 32'd0 : 32'd3);
      end
      t_mode = 1'b0;
      step();

      // First snapshot
      set_regs(1, 0);
      t_sel = 4'd5;
      step();
      t_req = 1'b1;
      step();
      t_req = 1'b0;
      check("cap busy", 32'(bus_a.o_snap_busy), 32'd1);
      check("cap valid pre", 32'(bus_a.o_snap_valid), 32'd0);
      wait_done(c);
      check("snap latency", 32'(c), 32'd16);
      check("done busy", 32'(bus_a.o_snap_busy), 32'd0);
      check("done valid", 32'(bus_a.o_snap_valid), 32'd1);
      check("snap sum1", bus_a.o_snap_sum, exp_sum1);
      set_regs(1, 100);
      step();
      check("view frozen out", bus_a.o_cpu_output, 32'd5);
      check("done pulse width", 32'(bus_a.o_snap_done), 32'd0);
      t_clr = 1'b1;
      step();
      t_clr = 1'b0;
      check("clr valid", 32'(bus_a.o_snap_valid), 32'd0);
      check("clr live out", bus_a.o_cpu_output, 32'd105);
      check("sum hold", bus_a.o_snap_sum, exp_sum1);

      // Snapshot again, then req+clr collision with req repeated during capture
      t_req = 1'b1;
      step();
      t_req = 1'b0;
      wait_done(c);
      check("snap2 latency", 32'(c), 32'd16);
      step();
      t_req = 1'b1; t_clr = 1'b1;
      step();
      check("coll busy", 32'(bus_a.o_snap_busy), 32'd1);
      check("coll valid", 32'(bus_a.o_snap_valid), 32'd1);
      step();
      t_req = 1'b0; t_clr = 1'b0;
      wait_done(c);
      check("coll latency", 32'(c + 1), 32'd16);
      check("coll valid end", 32'(bus_a.o_snap_valid), 32'd1);
      check("snap sum2", bus_a.o_snap_sum, exp_sum2);
      step();
      check("coll view out", bus_a.o_cpu_output, 32'd105);

      // Reset at capture cycle 7, launched from VIEW so snap_valid starts high
      t_req = 1'b1;
      step();
      t_req = 1'b0;
      repeat (7) step();
      check("mid busy pre", 32'(bus_a.o_snap_busy), 32'd1);
      check("mid valid pre", 32'(bus_a.o_snap_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid busy", 32'(bus_a.o_snap_busy), 32'd0);
      check("mid valid", 32'(bus_a.o_snap_valid), 32'd0);
      check("mid sum", bus_a.o_snap_sum, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      set_regs(1, 200);
      done_seen = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (bus_a.o_snap_done) done_seen++;
      end
      check("mid no done", 32'(done_seen), 32'd0);
      check("mid live out", bus_a.o_cpu_output, 32'd205);
      check("mid live idx", 32'(bus_a.o_view_idx), 32'd5);
      check("mid live valid", 32'(bus_a.o_snap_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cpu_output_scanner.md
Name: cpu_output_scanner

Overview:
- Parametrised successor to the fixed 4-bit output_sel viewer on CPU_FPGA.
- Drives CPU_OUTPUT from a register-file read port in two display modes:
  - manual: output_sel picks the register;
  - auto-scan: the index steps through all registers, holding each for DWELL_CYCLES.
- On request, captures an atomic snapshot of every register into a local buffer, so the board can show a frozen, consistent result while the CPU keeps running.
- Sits between the CPU register-file debug read port and the board outputs.

Parameters:
- DATA_W, 32, register and CPU_OUTPUT width.
- NUM_REGS, 16, number of registers scanned/snapshotted (2..2**SEL_W).
- SEL_W, 4, width of output_sel, reg_rd_addr and view_idx.
- DWELL_CYCLES, 8, clocks each index is held in auto-scan (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- mode  in  1  0 = manual select, 1 = auto-scan.
- output_sel  in  SEL_W  manual register index.
- snap_req  in  1  single-cycle pulse: take a snapshot.
- snap_clr  in  1  drop the snapshot and return to live view.
- reg_rd_addr  out  SEL_W  register-file read address.
- reg_rd_data  in  DATA_W  combinational read data for reg_rd_addr, same cycle.
- CPU_OUTPUT  out  DATA_W  displayed value, registered.
- view_idx  out  SEL_W  index currently shown, registered alongside CPU_OUTPUT.
- snap_valid  out  1  CPU_OUTPUT is sourced from the snapshot buffer.
- snap_busy  out  1  snapshot capture in progress.
- snap_done  out  1  one-cycle pulse when capture completes.
- snap_sum  out  DATA_W  snapshot checksum (see Optional Feature).

Behaviour:
- Reset (rst=0, async), all outputs and state cleared:
  - CPU_OUTPUT=0, view_idx=0, reg_rd_addr=0;
  - snap_valid=0, snap_busy=0, snap_done=0, snap_sum=0;
  - dwell counter=0, state=LIVE, buffer contents don't-care.
- Display index idx:
  - Manual: idx=output_sel. If output_sel>=NUM_REGS, CPU_OUTPUT shows 0 and view_idx shows output_sel.
  - Auto: idx advances every DWELL_CYCLES clocks and wraps NUM_REGS-1 -> 0.
  - Switching manual->auto seeds auto idx from the current output_sel (0 if out of range) and restarts the dwell counter.
- State LIVE:
  - reg_rd_addr=idx.
  - Each clock: CPU_OUTPUT <= reg_rd_data, view_idx <= idx. Latency 1 clock from output_sel change.
  - snap_req -> CAPTURE.
- State CAPTURE:
  - snap_busy=1; reg_rd_addr counts 0..NUM_REGS-1, one per clock; buf[addr] <= reg_rd_data.
  - CPU_OUTPUT and view_idx hold their last values; auto dwell counter frozen.
  - After address NUM_REGS-1 is written, next cycle: snap_done=1 for one clock, snap_busy=0, snap_valid=1, -> VIEW.
  - Capture takes exactly NUM_REGS clocks.
  - snap_req and snap_clr are ignored during CAPTURE.
- State VIEW:
  - Each clock: CPU_OUTPUT <= buf[idx] (0 if idx>=NUM_REGS), view_idx <= idx. reg_rd_addr=idx but unused.
  - snap_req -> CAPTURE (re-snapshot; snap_valid stays 1 until the new capture finishes).
  - snap_clr -> LIVE, snap_valid=0 next clock.
  - snap_req and snap_clr in the same cycle: snap_req wins.
- Reset asserted mid-CAPTURE: capture aborts immediately; after release the block is in LIVE with snap_valid=0.
- snap_sum: updated only at capture completion; holds between captures; cleared only by reset.

Optional Feature:
- Macro: SCAN_CHECKSUM_EN.
- Defined: during CAPTURE an accumulator starts from 0 and adds each captured word modulo 2**DATA_W. At snap_done, snap_sum takes the final sum.
- Undefined: no accumulator is built; snap_sum is tied to 0.

Test Plan:
- Reset then LIVE manual: rst=0 for 5 clocks -> all outputs 0. Release, regfile[4]=0x0000_0007, output_sel=4 -> CPU_OUTPUT=7 and view_idx=4 one clock later.
- Auto-scan wrap: NUM_REGS=16, DWELL_CYCLES=2, regfile[i]=i*3, mode=1 from output_sel=14 -> view_idx sequence 14,14,15,15,0,0 with CPU_OUTPUT 42,42,45,45,0,0.
- Snapshot atomicity: regfile[i]=i, pulse snap_req, then regfile changes to i+100 after capture -> snap_done exactly 16 clocks after snap_req; VIEW shows CPU_OUTPUT=5 for output_sel=5 (not 105). snap_clr -> 105 one clock later.
- Checksum (macro defined): regfile[i]=i, i=0..15 -> snap_sum=120 (0x78) at snap_done. Macro undefined -> snap_sum=0 throughout.
- Reset mid-capture: snap_req, then rst=0 at capture cycle 7 -> snap_busy=0 and snap_valid=0 immediately. No snap_done pulse; block resumes LIVE after release.
- Collisions and out-of-range:
  - snap_req+snap_clr together in VIEW -> re-capture, snap_valid remains 1.
  - snap_req during CAPTURE -> ignored, still 16-clock capture.
  - NUM_REGS=10, output_sel=12 -> CPU_OUTPUT=0, view_idx=12.
